branch_checkpoint_stack: RTL and testbench
==========================================

Name: branch_checkpoint_stack

Overview:
- Producer side of the free-list restore interface: supplies free_list_restore / restore_flag to the FreddyList on a branch mispredict.
- Checkpoints the post-dispatch free list when a branch dispatches, and tracks branch dependencies with one-hot masks.
- ORs retiring T_old registers into every live checkpoint so a restored list never leaks registers.
- Sits between dispatch, the branch-resolve path from execute, and the FreddyList.

Parameters:
- DEPTH, 4, number of checkpoint entries; also the branch-mask width.
- N, `N, superscalar width (retire ports).
- PHYS_REGS, `PHYS_REG_SZ_R10K, width of free-list bitvectors.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- branch_dispatch_valid  in  1  a branch dispatches this cycle; at most one per cycle.
- dispatch_free_list  in  PHYS_REGS  updated_free_list from dispatch, i.e. the checkpoint content.
- assigned_mask  out  DEPTH  one-hot entry allocated to the dispatching branch; 0 if none.
- branch_mask  out  DEPTH  valid vector of live checkpoints; dispatch tags instructions with it.
- stack_full  out  1  all DEPTH entries are valid.
- resolve_valid  in  1  a branch resolves this cycle.
- resolve_mask  in  DEPTH  one-hot entry being resolved.
- resolve_mispredict  in  1  1 = mispredict, 0 = correctly predicted.
- phys_reg_retiring  in  N x PHYS_REG_IDX  T_old registers being retired.
- num_retiring_valid  in  `NUM_SCALAR_BITS  count of valid retiring entries, lowest indices first.
- free_list_restore  out  PHYS_REGS  snapshot to restore.
- restore_flag  out  1  mispredict restore this cycle.
- squash_mask  out  DEPTH  entries killed by the current mispredict: the mispredicted entry plus all younger dependents.

Behaviour:
- Per-entry state:
  - valid bit.
  - snapshot[PHYS_REGS].
  - dep_mask[DEPTH], the live entries older than this one at allocation time.
- Reset: all registers clear, asynchronously. All outputs read 0: assigned_mask, branch_mask, stack_full, free_list_restore, restore_flag, squash_mask.

Allocation (combinational select, registered write):
- Target entry is the lowest-index entry that is invalid in the current-cycle state.
- assigned_mask is driven combinationally when branch_dispatch_valid and not full.
- On the clock edge, the selected entry is written as:
  - valid = 1.
  - snapshot = dispatch_free_list OR the retiring bits from this cycle.
  - dep_mask = branch_mask minus any entry resolved this cycle.
- Dispatch while full: ignored, assigned_mask = 0, no state change.
- A slot freed by a resolve this cycle is not reused until the next cycle.

Retire merge:
- Every cycle, for i < num_retiring_valid, bit phys_reg_retiring[i] is set in the snapshot of every valid entry.
- num_retiring_valid = 0 leaves all snapshots unchanged.

Correct resolve (resolve_valid, !resolve_mispredict, entry valid):
- The entry is cleared next edge.
- Its bit is cleared from every other entry's dep_mask.
- restore_flag = 0.

Mispredict (resolve_valid, resolve_mispredict, entry k valid):
- Same cycle, combinational, zero latency:
  - restore_flag = 1.
  - free_list_restore = snapshot[k] as currently stored (the FreddyList merges same-cycle retires itself).
  - squash_mask = bit k OR every valid entry whose dep_mask contains k.
- Next edge: all entries in squash_mask are invalidated.
- Any branch_dispatch_valid in the same cycle is dropped: no allocation, assigned_mask = 0, since that branch is younger and squashed.

Other boundary cases:
- Resolve targeting an invalid entry, or resolve_mask not one-hot: ignored. Outputs stay 0.
- free_list_restore is 0 whenever restore_flag = 0.
- resolve_valid = 0: no resolve effects.
- Reset asserted mid-operation overrides everything; there is no restore output during reset.

Decomposition:
- sys_defs package holds:
  - BRANCH_MASK typedef, logic[DEPTH-1:0].
  - `BRANCH_STACK_DEPTH constant.
  - CHECKPOINT_ENTRY struct {valid, snapshot, dep_mask}.
- PHYS_REG_IDX and `PHYS_REG_SZ_R10K are reused from the existing definitions.
- One natural sub-module, psel_lowest: a parameterised lowest-set-bit one-hot priority selector used for allocation.

Test Plan:
- Reset, then dispatch branches with dispatch_free_list = 64'h00FF, then 64'h00FE. Required: assigned_mask 0001 then 0010; branch_mask 0011; entry1 dep_mask 0001.
- Fill all 4 entries, then assert a 5th dispatch. Required: stack_full = 1, assigned_mask = 0000, state unchanged.
- With entries 0 and 1 live, retire phys regs 40 and 41 (num_retiring_valid = 2). Then mispredict entry 0. Required:
  - restore_flag = 1 in the same cycle.
  - free_list_restore = 64'h0300_0000_00FF.
  - squash_mask = 0011.
  - branch_mask = 0000 next cycle.
- Entries 0, 1, 2 live; correct-resolve entry 0. Then mispredict entry 1. Required: squash_mask = 0110, entry 2 is freed, restore uses entry 1's snapshot.
- Mispredict entry 0 in the same cycle as a branch dispatch. Required: assigned_mask = 0000 and no entry allocated next cycle.
- Assert reset while 3 entries are live and a mispredict is pending. Required: all outputs are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/branch_checkpoint_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_defs (package)
// Description : Shared definitions for the branch checkpoint stack:
//               processor-wide sizing macros, branch-mask and physical
//               register index types, and the checkpoint entry record.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef BRANCH_STACK_DEPTH
`define BRANCH_STACK_DEPTH 4
`endif
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

package sys_defs;

  localparam int c_BRANCH_DEPTH = `BRANCH_STACK_DEPTH;
  localparam int c_PHYS_REGS    = `PHYS_REG_SZ_R10K;

  typedef logic [c_BRANCH_DEPTH-1:0]          BRANCH_MASK;
  typedef logic [$clog2(c_PHYS_REGS)-1:0]     PHYS_REG_IDX;

  // One checkpoint: live flag, free-list snapshot, and the set of older
  // live branches this one depends on.
  typedef struct packed {
    logic                   valid;
    logic [c_PHYS_REGS-1:0] snapshot;
    BRANCH_MASK             dep_mask;
  } CHECKPOINT_ENTRY;

endpackage
`default_nettype wire

// File: rtl/branch_checkpoint_stack_psel.sv
`default_nettype none
// ============================================================================
// Module      : psel_lowest
// Description : One-hot priority selector, lowest set request bit wins.
// Ports       : req   - request vector
//               grant - one-hot grant (0 when req is 0)
// Revision    : 1.0 - initial release
// ============================================================================
module psel_lowest #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/branch_checkpoint_stack.sv
`default_nettype none
// ============================================================================
// Module      : branch_checkpoint_stack
// Description : Checkpoints the post-dispatch free list for each in-flight
//               branch, tracks branch dependencies with one-hot masks, merges
//               retiring T_old registers into live snapshots, and drives the
//               free-list restore on a mispredict (zero latency).
// Ports       : clock/reset            - clock, async active-high reset
//               branch_dispatch_valid  - branch dispatches this cycle
//               dispatch_free_list     - checkpoint content
//               assigned_mask          - one-hot entry given to the branch
//               branch_mask            - live checkpoint vector
//               stack_full             - all entries live
//               resolve_valid/mask/mispredict - branch resolution
//               phys_reg_retiring/num_retiring_valid - retiring T_old regs
//               free_list_restore/restore_flag - restore to the free list
//               squash_mask            - entries killed by a mispredict
// Revision    : 1.0 - initial release
// ============================================================================
module branch_checkpoint_stack
  import sys_defs::*;
#(
  parameter int DEPTH     = `BRANCH_STACK_DEPTH,
  parameter int N         = `N,
  parameter int PHYS_REGS = `PHYS_REG_SZ_R10K
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        branch_dispatch_valid,
  input  logic [PHYS_REGS-1:0]        dispatch_free_list,
  output logic [DEPTH-1:0]            assigned_mask,
  output logic [DEPTH-1:0]            branch_mask,
  output logic                        stack_full,
  input  logic                        resolve_valid,
  input  logic [DEPTH-1:0]            resolve_mask,
  input  logic                        resolve_mispredict,
  input  PHYS_REG_IDX                 phys_reg_retiring [N],
  input  logic [`NUM_SCALAR_BITS-1:0] num_retiring_valid,
  output logic [PHYS_REGS-1:0]        free_list_restore,
  output logic                        restore_flag,
  output logic [DEPTH-1:0]            squash_mask
);

  CHECKPOINT_ENTRY      r_entry [DEPTH];

  logic [DEPTH-1:0]     w_valid;
  logic [DEPTH-1:0]     w_sel;
  logic [PHYS_REGS-1:0] w_retire_bits;
  logic                 w_onehot;
  logic                 w_hit;
  logic                 w_mispredict;
  logic                 w_correct;
  logic [DEPTH-1:0]     w_squash;
  logic [PHYS_REGS-1:0] w_restore;
  logic [DEPTH-1:0]     w_alloc;
  logic [DEPTH-1:0]     w_resolved;

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign w_valid[g] = r_entry[g].valid;
  end

  psel_lowest #(.WIDTH(DEPTH)) u_psel (
    .req   (~w_valid),
    .grant (w_sel)
  );

  // Registers named by the first num_retiring_valid retire ports.
  always_comb begin
    w_retire_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(num_retiring_valid) > i) w_retire_bits[phys_reg_retiring[i]] = 1'b1;
    end
  end

  assign w_onehot     = (resolve_mask != '0) && ((resolve_mask & (resolve_mask - DEPTH'(1))) == '0);
  assign w_hit        = resolve_valid && w_onehot && ((resolve_mask & w_valid) != '0);
  assign w_mispredict = w_hit && resolve_mispredict;
  assign w_correct    = w_hit && !resolve_mispredict;
  assign w_resolved   = w_hit ? resolve_mask : '0;

  // Squash set: the mispredicted entry plus every live entry depending on it.
  always_comb begin
    w_squash  = '0;
    w_restore = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_mispredict && r_entry[i].valid &&
          (resolve_mask[i] || ((r_entry[i].dep_mask & resolve_mask) != '0)))
        w_squash[i] = 1'b1;
      if (w_mispredict && resolve_mask[i]) w_restore = w_restore | r_entry[i].snapshot;
    end
  end

  // A branch dispatching alongside a mispredict is younger and already dead.
  assign w_alloc = (branch_dispatch_valid && !w_mispredict) ? w_sel : '0;

  // Combinational outputs are forced quiet while reset is held.
  assign assigned_mask     = reset ? '0 : w_alloc;
  assign restore_flag      = !reset && w_mispredict;
  assign free_list_restore = reset ? '0 : w_restore;
  assign squash_mask       = reset ? '0 : w_squash;
  assign branch_mask       = w_valid;
  assign stack_full        = &w_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_squash[i] || (w_correct && resolve_mask[i])) begin
          r_entry[i] <= '0;
        end else if (w_alloc[i]) begin
          r_entry[i].valid    <= 1'b1;
          r_entry[i].snapshot <= dispatch_free_list | w_retire_bits;
          r_entry[i].dep_mask <= w_valid & ~w_resolved;
        end else if (r_entry[i].valid) begin
          r_entry[i].snapshot <= r_entry[i].snapshot | w_retire_bits;
          if (w_correct) r_entry[i].dep_mask <= r_entry[i].dep_mask & ~resolve_mask;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_checkpoint_stack
// Description : Directed self-checking bench for branch_checkpoint_stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_checkpoint_stack;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        branch_dispatch_valid = 1'b0;
  logic [63:0] dispatch_free_list = '0;
  logic [3:0]  assigned_mask;
  logic [3:0]  branch_mask;
  logic        stack_full;
  logic        resolve_valid = 1'b0;
  logic [3:0]  resolve_mask = '0;
  logic        resolve_mispredict = 1'b0;
  PHYS_REG_IDX phys_reg_retiring [2];
  logic [1:0]  num_retiring_valid = '0;
  logic [63:0] free_list_restore;
  logic        restore_flag;
  logic [3:0]  squash_mask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  branch_checkpoint_stack dut (
    .clock                 (clock),
    .reset                 (reset),
    .branch_dispatch_valid (branch_dispatch_valid),
    .dispatch_free_list    (dispatch_free_list),
    .assigned_mask         (assigned_mask),
    .branch_mask           (branch_mask),
    .stack_full            (stack_full),
    .resolve_valid         (resolve_valid),
    .resolve_mask          (resolve_mask),
    .resolve_mispredict    (resolve_mispredict),
    .phys_reg_retiring     (phys_reg_retiring),
    .num_retiring_valid    (num_retiring_valid),
    .free_list_restore     (free_list_restore),
    .restore_flag          (restore_flag),
    .squash_mask           (squash_mask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    phys_reg_retiring[0] = '0;
    phys_reg_retiring[1] = '0;
    #3;
    chk("rst_assigned", 64'(assigned_mask), 64'h0);
    chk("rst_bmask", 64'(branch_mask), 64'h0);
    chk("rst_full", 64'(stack_full), 64'h0);
    chk("rst_restore", free_list_restore, 64'h0);
    chk("rst_flag", 64'(restore_flag), 64'h0);
    chk("rst_squash", 64'(squash_mask), 64'h0);
    tick();
    reset = 1'b0;
    tick();

    // Two dispatches
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'h00FF;
    #1 chk("disp0_assigned", 64'(assigned_mask), 64'h1);
    tick();
    dispatch_free_list = 64'h00FE;
    #1 chk("disp1_assigned", 64'(assigned_mask), 64'h2);
    chk("disp1_bmask_pre", 64'(branch_mask), 64'h1);
    tick();
    branch_dispatch_valid = 1'b0;
    #1 chk("two_bmask", 64'(branch_mask), 64'h3);
    chk("two_full", 64'(stack_full), 64'h0);

    // Retire 40 and 41, then mispredict entry 0 with a same-cycle dispatch
    phys_reg_retiring[0] = 6'd40; phys_reg_retiring[1] = 6'd41; num_retiring_valid = 2'd2;
    tick();
    num_retiring_valid = 2'd0;
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b1;
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'hAA;
    #1 chk("mp0_flag", 64'(restore_flag), 64'h1);
    chk("mp0_restore", free_list_restore, 64'h0300_0000_00FF);
    chk("mp0_squash", 64'(squash_mask), 64'h3);
    chk("mp0_drop_assigned", 64'(assigned_mask), 64'h0);
    tick();
    resolve_valid = 1'b0; branch_dispatch_valid = 1'b0;
    #1 chk("mp0_bmask_after", 64'(branch_mask), 64'h0);
    chk("idle_flag", 64'(restore_flag), 64'h0);
    chk("idle_restore", free_list_restore, 64'h0);

    // Fill all four entries, then a fifth dispatch
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'h1;
    #1 chk("fill0", 64'(assigned_mask), 64'h1);
    tick(); dispatch_free_list = 64'h2;
    #1 chk("fill1", 64'(assigned_mask), 64'h2);
    tick(); dispatch_free_list = 64'h4;
    #1 chk("fill2", 64'(assigned_mask), 64'h4);
    tick(); dispatch_free_list = 64'h8;
    #1 chk("fill3", 64'(assigned_mask), 64'h8);
    tick(); dispatch_free_list = 64'hF0;
    #1 chk("full_flag", 64'(stack_full), 64'h1);
    chk("full_assigned", 64'(assigned_mask), 64'h0);
    tick();
    branch_dispatch_valid = 1'b0;
    #1 chk("full_bmask", 64'(branch_mask), 64'hF);

    // Non-one-hot resolve is ignored
    resolve_valid = 1'b1; resolve_mask = 4'b0011; resolve_mispredict = 1'b1;
    #1 chk("bad_flag", 64'(restore_flag), 64'h0);
    chk("bad_squash", 64'(squash_mask), 64'h0);
    chk("bad_restore", free_list_restore, 64'h0);
    tick();
    resolve_valid = 1'b0;
    #1 chk("bad_bmask", 64'(branch_mask), 64'hF);

    // Mispredict oldest kills all
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b1;
    #1 chk("mpall_squash", 64'(squash_mask), 64'hF);
    chk("mpall_restore", free_list_restore, 64'h1);
    tick();
    resolve_valid = 1'b0;
    #1 chk("mpall_bmask", 64'(branch_mask), 64'h0);

    // Three live, correct-resolve 0, mispredict 1
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'h10;
    tick(); dispatch_free_list = 64'h20;
    tick(); dispatch_free_list = 64'h40;
    tick(); branch_dispatch_valid = 1'b0;
    #1 chk("three_bmask", 64'(branch_mask), 64'h7);
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b0;
    #1 chk("cr_flag", 64'(restore_flag), 64'h0);
    chk("cr_squash", 64'(squash_mask), 64'h0);
    tick();
    resolve_mask = 4'b0010; resolve_mispredict = 1'b1;
    #1 chk("cr_bmask", 64'(branch_mask), 64'h6);
    chk("mp1_squash", 64'(squash_mask), 64'h6);
    chk("mp1_restore", free_list_restore, 64'h20);
    chk("mp1_flag", 64'(restore_flag), 64'h1);
    tick();
    resolve_valid = 1'b0;
    #1 chk("mp1_bmask", 64'(branch_mask), 64'h0);

    // Partial retire count merged into new checkpoint, then reset mid-mispredict
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'h100;
    phys_reg_retiring[0] = 6'd5; phys_reg_retiring[1] = 6'd63; num_retiring_valid = 2'd1;
    tick(); num_retiring_valid = 2'd0; dispatch_free_list = 64'h200;
    tick(); dispatch_free_list = 64'h400;
    tick(); branch_dispatch_valid = 1'b0;
    #1 chk("r3_bmask", 64'(branch_mask), 64'h7);
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b1;
    branch_dispatch_valid = 1'b1;
    #1 chk("r3_flag", 64'(restore_flag), 64'h1);
    chk("r3_restore", free_list_restore, 64'h120);
    chk("r3_squash", 64'(squash_mask), 64'h7);
    #1 reset = 1'b1;
    #1 chk("ar_assigned", 64'(assigned_mask), 64'h0);
    chk("ar_bmask", 64'(branch_mask), 64'h0);
    chk("ar_full", 64'(stack_full), 64'h0);
    chk("ar_restore", free_list_restore, 64'h0);
    chk("ar_flag", 64'(restore_flag), 64'h0);
    chk("ar_squash", 64'(squash_mask), 64'h0);
    resolve_valid = 1'b0; branch_dispatch_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_bmask", 64'(branch_mask), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
